// File: rtl/note_scheduler.sv
// Round-robin arbiter sharing one tone generator between NREQ requesters: each
// grant plays a note for NOTE_TICKS ticks and then forces GAP_TICKS ticks of silence.
// Optional macro SCHED_PREEMPT_EN gives requester 0 preempt priority during PLAY/GAP.
module note_scheduler #(
  parameter int NREQ       = 4,
  parameter int TICK_DIV   = 25000,
  parameter int NOTE_TICKS = 200,
  parameter int GAP_TICKS  = 20,
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [6*NREQ-1:0]    req_note,
  output logic [NREQ-1:0]      ack,
  output logic [7:0]           note,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

  localparam logic [19:0] PRESC_MAX = 20'(TICK_DIV - 1);
  localparam logic [15:0] NOTE_LAST = 16'(NOTE_TICKS - 1);
  localparam logic [15:0] GAP_LAST  = (GAP_TICKS > 0) ? 16'(GAP_TICKS - 1) : 16'd0;
  localparam logic        HAS_GAP   = (GAP_TICKS > 0);

  state_e            state_q, state_d;
  logic [7:0]        note_q, note_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [19:0]       presc_q, presc_d;
  logic [15:0]       tick_q, tick_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;
  logic [5:0]        win_note;
  logic              tick_end, play_done, gap_done, preempt, restart;

  // Requester 0 wins from PLAY/GAP unless it is itself the one playing.
`ifdef SCHED_PREEMPT_EN
  assign preempt = (state_q != S_IDLE) && req[0] && ((gid_q != '0) || (state_q == S_GAP));
`else
  assign preempt = 1'b0;
`endif

  // First asserted request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr_q + ID_W'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_note  = req_note[6*win_idx +: 6];
  assign tick_end  = (presc_q == PRESC_MAX);
  assign play_done = (state_q == S_PLAY) && tick_end && (tick_q == NOTE_LAST);
  assign gap_done  = (state_q == S_GAP)  && tick_end && (tick_q == GAP_LAST);

  always_ff @(posedge sysclk) begin
    // NOTE: synchronous reset inside the clocked block; all state uses non-blocking assignments.
    if (reset) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      ack_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      presc_q <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Next state and phase timers; the timers restart on every phase entry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (win_found) state_d = S_PLAY;
      S_PLAY: begin
        if (preempt)        state_d = S_PLAY;
        else if (play_done) state_d = HAS_GAP ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (preempt)       state_d = S_PLAY;
        else if (gap_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    restart = (state_d != state_q) || preempt;
    presc_d = '0;
    tick_d  = '0;
    if (!restart && state_q != S_IDLE) begin
      if (tick_end) begin
        tick_d = tick_q + 16'd1;
      end else begin
        presc_d = presc_q + 20'd1;
        tick_d  = tick_q;
      end
    end
  end

  // Registered outputs and round-robin pointer.
  always_comb begin
    note_d = note_q;
    ack_d  = '0;
    gid_d  = gid_q;
    busy_d = busy_q;
    ptr_d  = ptr_q;
    if (preempt) begin
      note_d   = {2'b00, req_note[5:0]};
      ack_d[0] = 1'b1;
      gid_d    = '0;
      busy_d   = 1'b1;
      ptr_d    = ID_W'(1);
    end else begin
      unique case (state_q)
        S_IDLE: if (win_found) begin
          note_d         = {2'b00, win_note};
          ack_d[win_idx] = 1'b1;
          gid_d          = win_idx;
          busy_d         = 1'b1;
          ptr_d          = win_idx + ID_W'(1);
        end
        S_PLAY: if (play_done) begin
          note_d = '0;
          busy_d = HAS_GAP;
        end
        S_GAP: if (gap_done) busy_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign ack      = ack_q;
  assign note     = note_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Round-robin scheduler that shares one tone generator between NREQ note requesters (key pads, sequencer, test source).
- Grants one request at a time and drives the generator's 8-bit note code for a fixed play time, then forces silence for a fixed gap.
- Note code 0 means silence, matching the tone generator's convention.
- Sits between the key decoders and the tone generator. Runs in the sysclk domain.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..8. Localparam ID_W = log2(NREQ).
- TICK_DIV, 25000, sysclk cycles per timing tick (1 ms at 25 MHz); >=1, <=2^20.
- NOTE_TICKS, 200, ticks a granted note is driven; >=1, <=65535.
- GAP_TICKS, 20, ticks of forced silence after each note; 0..65535.

Ports:
- sysclk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- req_note  input  6*NREQ  note code of requester i in bits [6i+5:6i]; held stable while req[i]=1.
- ack  output  NREQ  one-cycle grant pulse per requester.
- note  output  8  note code to tone generator; 0 = silent.
- grant_id  output  ID_W  index of the current/last granted requester.
- busy  output  1  high in PLAY and GAP.

Behaviour:
- Reset values (synchronous, active-high): state=IDLE, note=0, ack=0, grant_id=0, busy=0, rr pointer=0, prescaler=0, tick count=0. Reset mid-PLAY or mid-GAP silences note on the next edge. A request held through reset is served after reset.
- FSM states: IDLE, PLAY, GAP. All outputs are registered.
- IDLE arbitration:
  - Search req from the rr pointer upward, wrapping at NREQ-1 -> 0.
  - First asserted index k wins.
  - On that edge: state<=PLAY, note<={2'b00,req_note[k]}, grant_id<=k, ack[k]<=1 (one cycle only), busy<=1, pointer<=(k+1) mod NREQ.
  - No req: stay in IDLE, pointer unchanged.
- PLAY:
  - Prescaler and tick counter are cleared on entry.
  - Prescaler counts 0..TICK_DIV-1 and wraps; each wrap increments the tick count.
  - PLAY lasts exactly NOTE_TICKS*TICK_DIV cycles (note visible for that many cycles).
  - On exit: note<=0. Go to GAP if GAP_TICKS>0, otherwise IDLE.
- GAP:
  - Counters are cleared on entry. GAP lasts exactly GAP_TICKS*TICK_DIV cycles, then go to IDLE with busy<=0.
- IDLE latency: IDLE lasts at least one cycle between grants. Back-to-back grant spacing is (NOTE_TICKS+GAP_TICKS)*TICK_DIV+1 cycles.
- Handshake:
  - A requester holds req and req_note until it sees ack.
  - Dropping req before ack withdraws the request; no grant, no error.
  - req held high after ack is a new request and re-competes round-robin.
  - Requests arriving during PLAY/GAP wait.
- req_note=0 is granted as a rest: it occupies a full PLAY slot with note=0.
- req_note changes after ack are ignored; the latched note is held for the whole PLAY.
- No cycle has more than one ack bit set.

Optional Feature:
- Macro SCHED_PREEMPT_EN.
- Defined: requester 0 has preempt priority. In PLAY or GAP, if req[0]=1 and (grant_id!=0 or state==GAP), then on the next edge:
  - state<=PLAY, note<={2'b00,req_note[0]}, grant_id<=0, ack[0]<=1, pointer<=1, and the PLAY counters restart.
  - Requester 0 cannot preempt its own PLAY.
  - In IDLE, plain round-robin applies.
- Undefined: no preemption. The requester 0 path is identical to the others, and the preempt logic is absent from the netlist.

Test Plan:
Bench parameters: NREQ=4, TICK_DIV=4, NOTE_TICKS=3, GAP_TICKS=2 (PLAY=12 cycles, GAP=8 cycles).
1. After reset, req=4'b0100 with note 25 -> ack[2] pulse 1 cycle after req, note=25 for 12 cycles, note=0 and busy=1 for 8 cycles, then busy=0 and grant_id=2.
2. req=4'b1111 held with notes 26/28/31/33 on requesters 0..3 -> grant order 0,1,2,3,0, each grant 21 cycles apart, exactly one ack per grant.
3. req[1] raised at cycle 5 of PLAY, dropped at cycle 10 -> no ack[1], and IDLE stays idle after GAP.
4. Assert reset at cycle 6 of PLAY (note=30) -> next cycle note=0, busy=0, ack=0. Then req[3] still high -> granted first (pointer=0, search finds 3).
5. GAP_TICKS=0, req[0] held with note=0 -> note stays 0, busy toggles with a 1-cycle IDLE between 12-cycle PLAYs, ack[0] every 13 cycles.
6. SCHED_PREEMPT_EN defined: requester 2 playing note 35, req[0] (note 37) at PLAY cycle 4 -> next cycle note=37, ack[0]=1, grant_id=0, full 12-cycle PLAY follows. With the macro undefined, the same stimulus -> note 35 completes and requester 0 is granted after GAP.
